alu4_slice: RTL and testbench

Four-bit ALU slice with an internal carry-lookahead unit (LCU), group propagate/generate outputs for cascading, and a registered result stage. Four slices plus an external 4-group LCU using the same equations form the 16-bit datapath ALU. Combinational outputs serve the cascade; registered outputs (`*_q`) feed downstream pipeline logic.

---
 rtl/alu4_slice.sv | 99 +++++++++
 tb/tb_alu4_slice.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu4_slice.sv
// Purpose: 4-bit ALU slice with in-slice carry lookahead, group P/G for cascading, registered result.
// Latency: aluOut/cOut/pg/gg/ovf are combinational (0 cycles); *_q outputs load 1 cycle after en=1.
// Backpressure: none; en gates the result register, which holds its value while en=0.
//
// Ports:
//   clk, reset     rising-edge clock; asynchronous active-high reset clearing the *_q outputs
//   A, B, cIn      4-bit operands and carry in (LSB slice: tie cIn to ctrl[0])
//   ctrl           000/001 pass B, 010 add, 011 sub, 100 AND, 101 OR, 110 XOR, 111 zero
//   en             result-register load enable
//   aluOut, cOut   combinational result and carry out of bit 3
//   pg, gg         group propagate / generate for an external lookahead unit
//   ovf            signed overflow (c[3] ^ cOut), meaningful on the MSB slice for add/sub
//   aluOut_q, cOut_q, ovf_q, zero_q   registered copies; zero_q flags a zero result at load
module alu4_slice (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cIn,
    input  logic [2:0] ctrl,
    input  logic       en,
    output logic [3:0] aluOut,
    output logic       cOut,
    output logic       pg,
    output logic       gg,
    output logic       ovf,
    output logic [3:0] aluOut_q,
    output logic       cOut_q,
    output logic       ovf_q,
    output logic       zero_q
);

    logic [3:0] bx;
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    logic [3:0] sum;

    logic [3:0] aluOut_d;
    logic       cOut_d;
    logic       ovf_d;
    logic       zero_d;

    // Only subtract inverts B; the +1 for two's complement arrives through cIn.
    assign bx = (ctrl == 3'b011) ? ~B : B;
    assign p  = A ^ bx;
    assign g  = A & bx;

    // Flat two-level lookahead: every carry is a sum of products of p/g/cIn,
    // so no carry depends on another carry.
    assign c[0] = cIn;
    assign c[1] = g[0] | (p[0] & cIn);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cIn);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cIn);

    assign pg   = &p;
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    assign cOut = gg | (pg & cIn);
    assign ovf  = c[3] ^ cOut;

    assign sum  = p ^ c;

    always_comb begin
        aluOut = 4'h0;
        unique case (ctrl)
            3'b000,
            3'b001: aluOut = B;
            3'b010,
            3'b011: aluOut = sum;
            3'b100: aluOut = A & B;
            3'b101: aluOut = A | B;
            3'b110: aluOut = A ^ B;
            3'b111: aluOut = 4'h0;
            default: aluOut = 4'h0;
        endcase
    end

    assign aluOut_d = aluOut;
    assign cOut_d   = cOut;
    assign ovf_d    = ovf;
    assign zero_d   = (aluOut == 4'h0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aluOut_q <= 4'h0;
            cOut_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (en) begin
            aluOut_q <= aluOut_d;
            cOut_q   <= cOut_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu4_slice.sv
// Purpose: self-checking bench for alu4_slice: directed vectors, arithmetic model, 16-bit cascade.
// Latency: checks combinational outputs mid-cycle and registered outputs one edge after load.
// Backpressure: none; stimulus advances one vector per clock.
module tb_alu4_slice;

    logic       clk;
    logic       reset;
    logic [3:0] A;
    logic [3:0] B;
    logic       cIn;
    logic [2:0] ctrl;
    logic       en;
    logic [3:0] aluOut;
    logic       cOut;
    logic       pg;
    logic       gg;
    logic       ovf;
    logic [3:0] aluOut_q;
    logic       cOut_q;
    logic       ovf_q;
    logic       zero_q;

    int checks   = 0;
    int failures = 0;
    int rst_cnt  = 0;

    alu4_slice dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .cIn(cIn), .ctrl(ctrl), .en(en),
        .aluOut(aluOut), .cOut(cOut), .pg(pg), .gg(gg), .ovf(ovf),
        .aluOut_q(aluOut_q), .cOut_q(cOut_q), .ovf_q(ovf_q), .zero_q(zero_q)
    );

    // 16-bit cascade: four slices plus a lookahead unit built from the group equations.
    logic [15:0] ca;
    logic [15:0] cb;
    logic [2:0]  cctrl;
    logic [15:0] cres;
    logic [3:0]  cpg;
    logic [3:0]  cgg;
    logic [3:0]  ccout;
    logic [3:0]  covf;
    logic [3:0]  ccin;
    logic        cout16;
    logic [3:0]  cq_out [4];
    logic [3:0]  cq_c;
    logic [3:0]  cq_v;
    logic [3:0]  cq_z;

    assign ccin[0] = cctrl[0];
    assign ccin[1] = cgg[0] | (cpg[0] & ccin[0]);
    assign ccin[2] = cgg[1] | (cpg[1] & cgg[0]) | (cpg[1] & cpg[0] & ccin[0]);
    assign ccin[3] = cgg[2] | (cpg[2] & cgg[1]) | (cpg[2] & cpg[1] & cgg[0])
                   | (cpg[2] & cpg[1] & cpg[0] & ccin[0]);
    assign cout16  = cgg[3] | (cpg[3] & cgg[2]) | (cpg[3] & cpg[2] & cgg[1])
                   | (cpg[3] & cpg[2] & cpg[1] & cgg[0])
                   | (cpg[3] & cpg[2] & cpg[1] & cpg[0] & ccin[0]);

    for (genvar i = 0; i < 4; i++) begin : g_cas
        alu4_slice u_slice (
            .clk(clk), .reset(reset), .A(ca[4*i +: 4]), .B(cb[4*i +: 4]), .cIn(ccin[i]),
            .ctrl(cctrl), .en(1'b0),
            .aluOut(cres[4*i +: 4]), .cOut(ccout[i]), .pg(cpg[i]), .gg(cgg[i]), .ovf(covf[i]),
            .aluOut_q(cq_out[i]), .cOut_q(cq_c[i]), .ovf_q(cq_v[i]), .zero_q(cq_z[i])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic-level model: results from integer sums, not from lookahead equations.
    task automatic model(input logic [3:0] a, input logic [3:0] b, input logic ci,
                         input logic [2:0] op, output logic [3:0] r, output logic co,
                         output logic pgo, output logic ggo, output logic ov);
        logic [3:0] bx;
        logic [4:0] s5;
        bx  = (op == 3'b011) ? ~b : b;
        s5  = {1'b0, a} + {1'b0, bx} + {4'b0, ci};
        co  = s5[4];
        ov  = (a[3] == bx[3]) && (s5[3] != a[3]);
        pgo = ((a ^ bx) == 4'hF);
        ggo = (({1'b0, a} + {1'b0, bx}) > 5'd15);
        case (op)
            3'b000, 3'b001: r = b;
            3'b010, 3'b011: r = s5[3:0];
            3'b100:         r = a & b;
            3'b101:         r = a | b;
            3'b110:         r = a ^ b;
            default:        r = 4'h0;
        endcase
    endtask

    // Compare process: every falling edge, combinational outputs against the model
    // and registered outputs against the value the model predicted at the last load.
    logic [3:0] e_q_out = 4'h0;
    logic       e_q_c   = 1'b0;
    logic       e_q_v   = 1'b0;
    logic       e_q_z   = 1'b0;
    int         seen_rst = 0;

    always @(negedge clk) begin
        logic [3:0] r;
        logic co, pgo, ggo, ov;
        if (reset || (rst_cnt != seen_rst)) begin
            e_q_out = 4'h0; e_q_c = 1'b0; e_q_v = 1'b0; e_q_z = 1'b0;
            seen_rst = rst_cnt;
        end
        model(A, B, cIn, ctrl, r, co, pgo, ggo, ov);
        check("m_aluOut", {28'b0, aluOut}, {28'b0, r});
        check("m_cOut",   {31'b0, cOut},   {31'b0, co});
        check("m_pg",     {31'b0, pg},     {31'b0, pgo});
        check("m_gg",     {31'b0, gg},     {31'b0, ggo});
        check("m_ovf",    {31'b0, ovf},    {31'b0, ov});
        check("m_aluOut_q", {28'b0, aluOut_q}, {28'b0, e_q_out});
        check("m_cOut_q",   {31'b0, cOut_q},   {31'b0, e_q_c});
        check("m_ovf_q",    {31'b0, ovf_q},    {31'b0, e_q_v});
        check("m_zero_q",   {31'b0, zero_q},   {31'b0, e_q_z});
        if (!reset && en) begin
            e_q_out = r; e_q_c = co; e_q_v = ov; e_q_z = (r == 4'h0);
        end
    end

    // Inputs change 2 time units after a rising edge; literal checks follow at +4.
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci,
                         input logic [2:0] op, input logic e);
        @(posedge clk);
        #2;
        A = a; B = b; cIn = ci; ctrl = op; en = e;
        #2;
    endtask

    task automatic cas(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic [15:0] er, input logic ec);
        logic [16:0] s;
        @(posedge clk);
        #2;
        ca = a; cb = b; cctrl = op;
        #2;
        s = (op == 3'b011) ? ({1'b0, a} + {1'b0, ~b} + 17'd1) : ({1'b0, a} + {1'b0, b});
        check("cas_res_lit", {16'b0, cres}, {16'b0, er});
        check("cas_cout_lit", {31'b0, cout16}, {31'b0, ec});
        check("cas_res_mdl", {16'b0, cres}, {16'b0, s[15:0]});
        check("cas_cout_mdl", {31'b0, cout16}, {31'b0, s[16]});
    endtask

    initial begin
        reset = 1'b1; A = 4'h0; B = 4'h0; cIn = 1'b0; ctrl = 3'b000; en = 1'b0;
        ca = 16'h0; cb = 16'h0; cctrl = 3'b010;
        #3;
        check("rst_aluOut_q", {28'b0, aluOut_q}, 32'h0);
        check("rst_zero_q",   {31'b0, zero_q},   32'h0);
        check("rst_cOut_q",   {31'b0, cOut_q},   32'h0);
        @(posedge clk); #2; reset = 1'b0;

        // Pass
        drive(4'hA, 4'hC, 1'b0, 3'b000, 1'b0); check("pass_C", {28'b0, aluOut}, 32'hC);
        drive(4'h5, 4'h3, 1'b0, 3'b000, 1'b0); check("pass_3", {28'b0, aluOut}, 32'h3);
        drive(4'h5, 4'h9, 1'b0, 3'b001, 1'b0); check("pass_alias", {28'b0, aluOut}, 32'h9);

        // Add
        drive(4'h1, 4'h1, 1'b0, 3'b010, 1'b0);
        check("add_1_1", {28'b0, aluOut}, 32'h2); check("add_1_1_c", {31'b0, cOut}, 32'h0);
        drive(4'h7, 4'h1, 1'b0, 3'b010, 1'b0);
        check("add_7_1", {28'b0, aluOut}, 32'h8); check("add_7_1_c", {31'b0, cOut}, 32'h0);
        check("add_7_1_ovf", {31'b0, ovf}, 32'h1);
        drive(4'hF, 4'h1, 1'b0, 3'b010, 1'b0);
        check("add_F_1", {28'b0, aluOut}, 32'h0); check("add_F_1_c", {31'b0, cOut}, 32'h1);
        check("add_F_1_pg", {31'b0, pg}, 32'h0); check("add_F_1_gg", {31'b0, gg}, 32'h1);
        drive(4'hF, 4'hF, 1'b0, 3'b010, 1'b0);
        check("add_F_F", {28'b0, aluOut}, 32'hE); check("add_F_F_c", {31'b0, cOut}, 32'h1);
        drive(4'h5, 4'hA, 1'b1, 3'b010, 1'b0);
        check("add_pg_cin", {28'b0, aluOut}, 32'h0); check("add_pg_cin_c", {31'b0, cOut}, 32'h1);

        // Subtract
        drive(4'hC, 4'hC, 1'b1, 3'b011, 1'b0);
        check("sub_C_C", {28'b0, aluOut}, 32'h0); check("sub_C_C_c", {31'b0, cOut}, 32'h1);
        drive(4'hC, 4'hA, 1'b1, 3'b011, 1'b0);
        check("sub_C_A", {28'b0, aluOut}, 32'h2); check("sub_C_A_c", {31'b0, cOut}, 32'h1);
        drive(4'hA, 4'hC, 1'b1, 3'b011, 1'b0);
        check("sub_A_C", {28'b0, aluOut}, 32'hE); check("sub_A_C_c", {31'b0, cOut}, 32'h0);

        // Logic ops with A=0/F/A, B=0/F/5; cIn=1 must not matter
        drive(4'h0, 4'h0, 1'b1, 3'b100, 1'b0); check("and_0", {28'b0, aluOut}, 32'h0);
        drive(4'hF, 4'hF, 1'b1, 3'b100, 1'b0); check("and_F", {28'b0, aluOut}, 32'hF);
        drive(4'hA, 4'h5, 1'b1, 3'b100, 1'b0); check("and_A5", {28'b0, aluOut}, 32'h0);
        drive(4'h0, 4'h0, 1'b1, 3'b101, 1'b0); check("or_0", {28'b0, aluOut}, 32'h0);
        drive(4'hF, 4'hF, 1'b1, 3'b101, 1'b0); check("or_F", {28'b0, aluOut}, 32'hF);
        drive(4'hA, 4'h5, 1'b1, 3'b101, 1'b0); check("or_A5", {28'b0, aluOut}, 32'hF);
        drive(4'h0, 4'h0, 1'b1, 3'b110, 1'b0); check("xor_0", {28'b0, aluOut}, 32'h0);
        drive(4'hF, 4'hF, 1'b1, 3'b110, 1'b0); check("xor_F", {28'b0, aluOut}, 32'h0);
        drive(4'hA, 4'h5, 1'b1, 3'b110, 1'b0); check("xor_A5", {28'b0, aluOut}, 32'hF);
        drive(4'hF, 4'hF, 1'b1, 3'b111, 1'b0); check("zero_op", {28'b0, aluOut}, 32'h0);

        // Register: load 2, hold, reset pulse between edges, zero flag
        drive(4'h1, 4'h1, 1'b0, 3'b010, 1'b1);
        @(posedge clk); #1;
        check("reg_load2", {28'b0, aluOut_q}, 32'h2); check("reg_load2_z", {31'b0, zero_q}, 32'h0);
        #1; A = 4'h7; B = 4'h7; en = 1'b0;
        @(posedge clk); #1;
        check("reg_hold", {28'b0, aluOut_q}, 32'h2);
        drive(4'hF, 4'h1, 1'b0, 3'b010, 1'b1);
        @(posedge clk); #1;
        check("reg_load0_c", {31'b0, cOut_q}, 32'h1); check("reg_load0_z", {31'b0, zero_q}, 32'h1);
        #1; en = 1'b0; reset = 1'b1; rst_cnt++;
        #1;
        check("rst_pulse_q", {28'b0, aluOut_q}, 32'h0); check("rst_pulse_c", {31'b0, cOut_q}, 32'h0);
        check("rst_pulse_z", {31'b0, zero_q}, 32'h0);
        reset = 1'b0;
        drive(4'h0, 4'h0, 1'b0, 3'b010, 1'b1);
        @(posedge clk); #1;
        check("reg_zero", {31'b0, zero_q}, 32'h1); check("reg_zero_q", {28'b0, aluOut_q}, 32'h0);
        #1; en = 1'b0;

        // 16-bit cascade
        cas(16'hFFFF, 16'h0001, 3'b010, 16'h0000, 1'b1);
        cas(16'hC000, 16'h4CA8, 3'b010, 16'h0CA8, 1'b1);
        cas(16'hCCAA, 16'h3356, 3'b010, 16'h0000, 1'b1);
        cas(16'hAAAA, 16'hCCCC, 3'b011, 16'hDDDE, 1'b0);

        @(posedge clk); @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
